// File: rtl/clk_enable_divider.sv
// Clock-enable generator: divides clk by DIV into a one-cycle tick, a toggling
// slow_en level and a wrapping tick count, gated by a start/stop run FSM.
module clk_enable_divider #(
  parameter int unsigned DIV_SYNTH = 50_000_000,
  parameter int unsigned DIV_SIM   = 5,
  parameter int unsigned TICKS_W   = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               clr,
  output logic               tick,
  output logic               slow_en,
  output logic [TICKS_W-1:0] tick_count,
  output logic               running
);

`ifdef SIM
  localparam bit USE_SIM = 1'b1;
`else
  localparam bit USE_SIM = 1'b0;
`endif

  localparam int unsigned DIV  = USE_SIM ? DIV_SIM : DIV_SYNTH;
  localparam int unsigned CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERM = CW'(DIV - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  // NOTE: all state here is registered with non-blocking assignments so every
  // branch reads the pre-edge value of state/cnt, which is what makes a stop
  // on the terminal edge still issue its tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      running    <= 1'b0;
      cnt        <= '0;
      tick       <= 1'b0;
      slow_en    <= 1'b0;
      tick_count <= '0;
    end else begin
      // Run control is independent of clr so a same-edge start/stop still lands.
      case (state)
        IDLE: begin
          if (start && !stop) begin
            state   <= RUN;
            running <= 1'b1;
          end
        end
        RUN: begin
          if (stop) begin
            state   <= IDLE;
            running <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          running <= 1'b0;
        end
      endcase

      if (clr) begin
        cnt        <= '0;
        tick       <= 1'b0;
        slow_en    <= 1'b0;
        tick_count <= '0;
      end else if (state == RUN) begin
        if (cnt == TERM) begin
          cnt        <= '0;
          tick       <= 1'b1;
          slow_en    <= ~slow_en;
          tick_count <= tick_count + 1'b1;
        end else begin
          cnt  <= cnt + 1'b1;
          tick <= 1'b0;
        end
      end else begin
        tick <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_clk_enable_divider.sv
// Bench for clk_enable_divider: a DIV=5 and a DIV=1 instance share stimulus and
// are checked every cycle against an arithmetic run-edge model plus literals.
module tb_clk_enable_divider;

  localparam int DIV_A = 5;
  localparam int W_A   = 8;
  localparam int DIV_B = 1;
  localparam int W_B   = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0, stop = 1'b0, clr = 1'b0;

  logic           tick_a, slow_a, run_a;
  logic [W_A-1:0] count_a;
  logic           tick_b, slow_b, run_b;
  logic [W_B-1:0] count_b;

  int vectors = 0;
  int miscompares = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  clk_enable_divider #(.DIV_SYNTH(DIV_A), .DIV_SIM(DIV_A), .TICKS_W(W_A)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr),
    .tick(tick_a), .slow_en(slow_a), .tick_count(count_a), .running(run_a)
  );

  clk_enable_divider #(.DIV_SYNTH(DIV_B), .DIV_SIM(DIV_B), .TICKS_W(W_B)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clr(clr),
    .tick(tick_b), .slow_en(slow_b), .tick_count(count_b), .running(run_b)
  );

  // Model: m_n counts RUN edges since the last clear; every output follows
  // from that total by division (ticks issued = m_n / DIV).
  longint m_n [2];
  bit     m_tick [2];
  bit     m_run;

  function automatic int div_of(input int i);
    return (i == 0) ? DIV_A : DIV_B;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        m_n[i]    <= 0;
        m_tick[i] <= 1'b0;
      end
    end else begin
      m_run <= m_run ? !stop : (start && !stop);
      for (int i = 0; i < 2; i++) begin
        if (clr) begin
          m_n[i]    <= 0;
          m_tick[i] <= 1'b0;
        end else if (m_run) begin
          m_n[i]    <= m_n[i] + 1;
          m_tick[i] <= ((m_n[i] + 1) % div_of(i)) == 0;
        end else begin
          m_tick[i] <= 1'b0;
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en) begin
      check("tick_a",  32'(tick_a),  32'(m_tick[0]));
      check("slow_a",  32'(slow_a),  32'((m_n[0] / DIV_A) % 2));
      check("count_a", 32'(count_a), 32'((m_n[0] / DIV_A) % (64'd1 << W_A)));
      check("run_a",   32'(run_a),   32'(m_run));
      check("tick_b",  32'(tick_b),  32'(m_tick[1]));
      check("slow_b",  32'(slow_b),  32'((m_n[1] / DIV_B) % 2));
      check("count_b", 32'(count_b), 32'((m_n[1] / DIV_B) % (64'd1 << W_B)));
      check("run_b",   32'(run_b),   32'(m_run));
    end
  end

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_tick_a"},  32'(tick_a),  0);
    check({name, "_slow_a"},  32'(slow_a),  0);
    check({name, "_count_a"}, 32'(count_a), 0);
    check({name, "_run_a"},   32'(run_a),   0);
    check({name, "_tick_b"},  32'(tick_b),  0);
    check({name, "_count_b"}, 32'(count_b), 0);
    check({name, "_run_b"},   32'(run_b),   0);
  endtask

  task automatic halt_and_clear();
    stop = 1'b1;
    step();
    stop = 1'b0;
    clr  = 1'b1;
    step();
    clr  = 1'b0;
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #20 check_all_zero("reset");
    @(negedge clk);
    rst_n  = 1'b1;
    cmp_en = 1'b1;

    // Start at E0, run 16 edges: DIV=5 ticks after E5/E10/E15, DIV=1 every edge.
    start = 1'b1;
    step();
    start = 1'b0;
    check("t1_run_e0",  32'(run_a),  1);
    check("t1_tick_e0", 32'(tick_a), 0);
    for (int k = 1; k <= 16; k++) begin
      step();
      check("t1_tick_a",  32'(tick_a),  32'(k % 5 == 0));
      check("t1_tick_b",  32'(tick_b),  1);
      check("t1_count_b", 32'(count_b), 32'(k % 8));
      check("t1_slow_b",  32'(slow_b),  32'(k % 2));
      if (k % 5 == 0) begin
        check("t1_count_a", 32'(count_a), 32'(k / 5));
        check("t1_slow_a",  32'(slow_a),  32'((k / 5) % 2));
      end
    end
    halt_and_clear();
    check("halt_run", 32'(run_a), 0);

    // Pause at E3, resume at E14: remaining edges finish the period at E16.
    for (int e = 0; e <= 22; e++) begin
      start = (e == 0) || (e == 14);
      stop  = (e == 3);
      step();
      check("t2_tick_a", 32'(tick_a), 32'((e == 16) || (e == 21)));
    end
    start = 1'b0;
    stop  = 1'b0;
    halt_and_clear();

    // start and stop together while idle: no transition.
    start = 1'b1;
    stop  = 1'b1;
    step();
    start = 1'b0;
    stop  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      check("t3_run_a",  32'(run_a),  0);
      check("t3_tick_a", 32'(tick_a), 0);
      step();
    end

    // Asynchronous reset between edges mid-count.
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      step();
      check("t5_tick_a", 32'(tick_a), 0);
      check("t5_run_a",  32'(run_a),  0);
    end

    // clr on the terminal-count edge suppresses that tick only.
    for (int e = 0; e <= 11; e++) begin
      start = (e == 0);
      clr   = (e == 5);
      step();
      check("t6_tick_a", 32'(tick_a), 32'(e == 10));
      if (e == 5) begin
        check("t6_count_clr", 32'(count_a), 0);
        check("t6_run_clr",   32'(run_a),   1);
      end
      if (e == 10) check("t6_count_next", 32'(count_a), 1);
    end
    start = 1'b0;
    clr   = 1'b0;

    // Randomized control traffic, including occasional async reset pulses.
    for (int n = 0; n < 3000; n++) begin
      start = ($urandom_range(0, 7) == 0);
      stop  = ($urandom_range(0, 11) == 0);
      clr   = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        #1 rst_n = 1'b1;
      end
      step();
    end
    start = 1'b0;
    stop  = 1'b0;
    clr   = 1'b0;
    step();
    cmp_en = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
